// File: rtl/led_scan_pkg.sv
// Shared types and constants for the LED scan controller.
// Holds the FSM states, mode codes, enables and the position stepper.
package led_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE
  } state_t;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PING = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  localparam logic [2:0] EN_ON  = 3'b100;
  localparam logic [2:0] EN_OFF = 3'b000;

  typedef struct packed {
    logic       dir_up;
    logic [2:0] pos;
  } scan_t;

  function automatic scan_t next_scan(
    input scan_t      cur,
    input logic [1:0] mode
  );
    scan_t n;
    n = cur;
    unique case (1'b1)
      (mode == MODE_UP):   n.pos = cur.pos + 3'd1;
      (mode == MODE_DOWN): n.pos = cur.pos - 3'd1;
      (mode == MODE_PING): begin
        // Endpoints bounce so each is shown for one period only.
        if (cur.dir_up) begin
          if (cur.pos == 3'd7) begin
            n.pos    = 3'd6;
            n.dir_up = 1'b0;
          end else begin
            n.pos = cur.pos + 3'd1;
          end
        end else begin
          if (cur.pos == 3'd0) begin
            n.pos    = 3'd1;
            n.dir_up = 1'b1;
          end else begin
            n.pos = cur.pos - 3'd1;
          end
        end
      end
      default: n = cur;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/led_scan_prescaler.sv
// Advance-rate prescaler: one tick every div+1 enabled cycles.
// A count above div (div lowered mid-run) ticks and wraps at once.
module led_scan_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt >= div);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/led_scan_ctrl.sv
// LED scan controller: IDLE/RUN/PAUSE sequencer driving a
// 3-to-8 decoder index and enable, all outputs registered.
module led_scan_ctrl
  import led_scan_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  output logic [2:0]       switch,
  output logic [2:0]       enable,
  output logic             busy,
  output logic             lap
);

  state_t state;
  scan_t  scan;
  scan_t  nxt;
  logic   tick;
  logic   in_run;
  logic   nxt_lap;

  assign in_run  = (state == ST_RUN);
  assign nxt     = next_scan(scan, mode);
  assign nxt_lap = (nxt.pos == 3'd0) && (scan.pos != 3'd0);
  assign switch  = scan.pos;

  // Held at zero outside RUN, so every RUN entry starts a fresh period.
  led_scan_prescaler #(
    .DIV_W(DIV_W)
  ) u_presc (
    .clk (clk),
    .rst (rst),
    .clr (!in_run),
    .en  (in_run),
    .div (div),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      scan   <= '{dir_up: 1'b1, pos: 3'd0};
      enable <= EN_OFF;
      busy   <= 1'b0;
      lap    <= 1'b0;
    end else begin
      lap <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_RUN;
            scan   <= '{dir_up: 1'b1, pos: 3'd0};
            enable <= EN_ON;
            busy   <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state <= ST_PAUSE;
            busy  <= 1'b0;
          end else if (tick) begin
            scan <= nxt;
            lap  <= nxt_lap;
          end
        end
        ST_PAUSE: begin
          if (stop) begin
            state  <= ST_IDLE;
            scan   <= '{dir_up: 1'b1, pos: 3'd0};
            enable <= EN_OFF;
          end else if (start) begin
            state <= ST_RUN;
            busy  <= 1'b1;
          end else if (step) begin
            scan <= nxt;
            lap  <= nxt_lap;
          end
        end
        default: begin
          state  <= ST_IDLE;
          scan   <= '{dir_up: 1'b1, pos: 3'd0};
          enable <= EN_OFF;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
